// File: rtl/bitmap_sprite_renderer.sv
// Single-sprite 1-bpp bitmap renderer.
// Holds a writable SPR_H x SPR_W bitmap and fetches one row per scanline during
// horizontal blank. Each bitmap bit is replicated into a 2^SCALE_LOG2 square of
// screen pixels. Sprite position updates are accepted through a valid/ready
// handshake and become active only at the frame boundary, so a frame never tears.
// Every output is registered one cycle after the sync inputs it belongs to.
// Optional feature macro: BITMAP_SPRITE_MIRROR_EN adds i_mirror, which selects a
// horizontal flip. The flip is latched with the position and applied at the frame
// boundary.
module bitmap_sprite_renderer #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned SPR_W      = 16,
  parameter int unsigned SPR_H      = 16,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [9:0]               i_hpos,
  input  logic [9:0]               i_vpos,
  input  logic                     i_visible,
  input  logic                     i_wr_en,
  input  logic [$clog2(SPR_H)-1:0] i_wr_row,
  input  logic [SPR_W-1:0]         i_wr_data,
  input  logic                     i_pos_valid,
  output logic                     o_pos_ready,
  input  logic [9:0]               i_pos_x,
  input  logic [9:0]               i_pos_y,
`ifdef BITMAP_SPRITE_MIRROR_EN
  input  logic                     i_mirror,
`endif
  output logic [9:0]               o_hpos,
  output logic [9:0]               o_vpos,
  output logic                     o_visible,
  output logic [7:0]               o_r,
  output logic [7:0]               o_g,
  output logic [7:0]               o_b
);

  localparam int unsigned ROW_W = $clog2(SPR_H);
  localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

  localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'((1 << SCALE_LOG2) - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
  localparam logic [10:0]      SPAN_V   = 11'(SPR_H << SCALE_LOG2);
  localparam logic [9:0]       H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StArmed, StDraw} state_t;

  // Bitmap storage (intentionally not reset)
  logic [SPR_W-1:0] ram [SPR_H];

  // Position staging
  logic       pend_full;
  logic [9:0] pend_x, pend_y;
  logic [9:0] pos_x, pos_y;
  logic       mirror_on;

  // Line engine
  state_t           state;
  logic             hit;
  logic [SPR_W-1:0] shreg;
  logic [COL_W-1:0] col;
  logic [SUB_W-1:0] sub;

  // Combinational helpers
  logic             boundary;
  logic             handshake;
  logic [9:0]       next_line;
  logic [10:0]      rel;
  logic             load_hit;
  logic [ROW_W-1:0] load_row;
  logic             start;
  logic             draw_now;
  logic [COL_W-1:0] col_cur;
  logic [SUB_W-1:0] sub_cur;
  logic [COL_W-1:0] col_nx;
  logic [SUB_W-1:0] sub_nx;
  logic             last_px;
  logic [COL_W-1:0] bit_idx;
  logic             cur_bit;
  logic [23:0]      pix;

  assign boundary    = (i_hpos == '0) && (i_vpos == V_VIS);
  assign handshake   = i_pos_valid && !pend_full;
  assign o_pos_ready = !pend_full;

  // Bitmap row writes; a fetch in the same cycle sees the previous contents
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      ram[i_wr_row] <= i_wr_data;
    end
  end

`ifdef BITMAP_SPRITE_MIRROR_EN
  logic pend_mirror;
  logic act_mirror;

  // Position and mirror staging: latch on handshake, promote at frame boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_full   <= 1'b0;
      pend_x      <= '0;
      pend_y      <= '0;
      pend_mirror <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      act_mirror  <= 1'b0;
    end else begin
      if (handshake) begin
        pend_x      <= i_pos_x;
        pend_y      <= i_pos_y;
        pend_mirror <= i_mirror;
        pend_full   <= 1'b1;
      end
      // A handshake on the boundary cycle itself found pend_full low, so it
      // waits for the next boundary.
      if (boundary && pend_full) begin
        pos_x      <= pend_x;
        pos_y      <= pend_y;
        act_mirror <= pend_mirror;
        pend_full  <= 1'b0;
      end
    end
  end

  assign mirror_on = act_mirror;
`else
  // Position staging: latch on handshake, promote at frame boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_full <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
    end else begin
      if (handshake) begin
        pend_x    <= i_pos_x;
        pend_y    <= i_pos_y;
        pend_full <= 1'b1;
      end
      // A handshake on the boundary cycle itself found pend_full low, so it
      // waits for the next boundary.
      if (boundary && pend_full) begin
        pos_x     <= pend_x;
        pos_y     <= pend_y;
        pend_full <= 1'b0;
      end
    end
  end

  assign mirror_on = 1'b0;
`endif

  // Row selection for the line that follows the current one
  always_comb begin
    next_line = (i_vpos == V_LAST) ? 10'd0 : i_vpos + 10'd1;
    rel       = {1'b0, next_line} - {1'b0, pos_y};
    load_hit  = !rel[10] && (rel < SPAN_V);
    load_row  = rel[SCALE_LOG2 +: ROW_W];
  end

  // Current pixel selection and counter advance
  always_comb begin
    start = (state == StArmed) && (i_hpos != H_VIS) && hit && i_visible &&
            (i_hpos == pos_x) && (pos_x < H_VIS);
    draw_now = i_visible && (start || ((state == StDraw) && (i_hpos != H_VIS)));

    // The start cycle emits column 0, subpixel 0.
    col_cur = (state == StDraw) ? col : '0;
    sub_cur = (state == StDraw) ? sub : '0;

    if (sub_cur == SUB_MAX) begin
      sub_nx = '0;
      col_nx = col_cur + 1'b1;
    end else begin
      sub_nx = sub_cur + 1'b1;
      col_nx = col_cur;
    end
    last_px = (col_cur == COL_LAST) && (sub_cur == SUB_MAX);

    // Column 0 is the row MSB unless mirrored
    bit_idx = mirror_on ? col_cur : (COL_LAST - col_cur);
    cur_bit = shreg[bit_idx];

    if (draw_now && cur_bit) begin
      pix = FG_RGB;
    end else if (i_visible) begin
      pix = BG_RGB;
    end else begin
      pix = 24'h000000;
    end
  end

  // Line FSM: fetch in horizontal blank, wait for pos_x, replicate bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= StIdle;
      hit   <= 1'b0;
      shreg <= '0;
      col   <= '0;
      sub   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (i_hpos == H_VIS) begin
            state <= StLoad;
          end
        end
        StLoad: begin
          hit <= load_hit;
          if (load_hit) begin
            shreg <= ram[load_row];
          end
          state <= StArmed;
        end
        StArmed: begin
          if (i_hpos == H_VIS) begin
            state <= StLoad;
          end else if (start) begin
            // Counters enter DRAW already pointing at the second screen pixel
            // because the start cycle outputs the first one.
            if (last_px) begin
              state <= StIdle;
            end else begin
              state <= StDraw;
              col   <= col_nx;
              sub   <= sub_nx;
            end
          end
        end
        StDraw: begin
          if (i_hpos == H_VIS) begin
            state <= StLoad;
          end else if (last_px) begin
            state <= StIdle;
          end else begin
            col <= col_nx;
            sub <= sub_nx;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Registered outputs, one cycle behind the sync inputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hpos    <= '0;
      o_vpos    <= '0;
      o_visible <= 1'b0;
      o_r       <= '0;
      o_g       <= '0;
      o_b       <= '0;
    end else begin
      o_hpos    <= i_hpos;
      o_vpos    <= i_vpos;
      o_visible <= i_visible;
      o_r       <= pix[23:16];
      o_g       <= pix[15:8];
      o_b       <= pix[7:0];
    end
  end

endmodule

// File: tb/tb_bitmap_sprite_renderer.sv
// Directed bench for bitmap_sprite_renderer with default parameters.
// Scanlines are driven sparsely: only the blanking tail of the previous line and
// the line of interest are generated, with frame boundaries inserted explicitly.
module tb_bitmap_sprite_renderer;

  logic       clk;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       visible;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [15:0] wr_data;
  logic       pos_valid;
  logic       pos_ready;
  logic [9:0] pos_x, pos_y;
  logic       mirror;
  logic [9:0] o_hpos, o_vpos;
  logic       o_visible;
  logic [7:0] o_r, o_g, o_b;

  int checks   = 0;
  int failures = 0;

  logic [23:0] line_rgb [0:1023];

  bitmap_sprite_renderer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hpos      (hpos),
    .i_vpos      (vpos),
    .i_visible   (visible),
    .i_wr_en     (wr_en),
    .i_wr_row    (wr_row),
    .i_wr_data   (wr_data),
    .i_pos_valid (pos_valid),
    .o_pos_ready (pos_ready),
    .i_pos_x     (pos_x),
    .i_pos_y     (pos_y),
`ifdef BITMAP_SPRITE_MIRROR_EN
    .i_mirror    (mirror),
`endif
    .o_hpos      (o_hpos),
    .o_vpos      (o_vpos),
    .o_visible   (o_visible),
    .o_r         (o_r),
    .o_g         (o_g),
    .o_b         (o_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One pixel clock; outputs sampled afterwards belong to (h, v)
  task automatic cycle(input int h, input int v);
    @(negedge clk);
    hpos    = 10'(h);
    vpos    = 10'(v);
    visible = (h < 640) && (v < 480);
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_row  = 4'(r);
    wr_data = d;
    cycle(700, 500);
    wr_en   = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y, input logic m, input int h, input int v);
    pos_valid = 1'b1;
    pos_x     = 10'(x);
    pos_y     = 10'(y);
    mirror    = m;
    cycle(h, v);
    pos_valid = 1'b0;
  endtask

  // Blanking tail of the previous line (triggers the fetch), then line v
  task automatic run_line(input int v);
    int prev;
    int mis;
    prev = (v == 0) ? 524 : v - 1;
    mis  = 0;
    for (int h = 640; h < 644; h++) cycle(h, prev);
    for (int h = 0; h < 660; h++) begin
      cycle(h, v);
      line_rgb[h] = {o_r, o_g, o_b};
      if (o_hpos !== 10'(h) || o_vpos !== 10'(v)) mis++;
    end
    check("hpos_vpos_align", mis, 0);
  endtask

  initial begin
    rst_n = 1'b1; hpos = '0; vpos = '0; visible = 1'b0;
    wr_en = 1'b0; wr_row = '0; wr_data = '0;
    pos_valid = 1'b0; pos_x = '0; pos_y = '0; mirror = 1'b0;

    // Asynchronous reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_rgb", {o_r, o_g, o_b}, 24'h000000);
    check("rst_hpos", o_hpos, 0);
    check("rst_vpos", o_vpos, 0);
    check("rst_visible", o_visible, 0);
    check("rst_ready", pos_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(10, 10);
    check("visible_delay", o_visible, 1);

    for (int r = 0; r < 16; r++) write_row(r, 16'h0000);
    write_row(0, 16'h8001);
    write_row(1, 16'h4000);

    // Basic draw at (100,50), scale 2
    set_pos(100, 50, 1'b0, 700, 500);
    check("ready_low_after_hs", pos_ready, 0);
    cycle(0, 480);
    check("ready_high_after_boundary", pos_ready, 1);
    run_line(50);
    check("l50_h99",  line_rgb[99],  24'h000000);
    check("l50_h100", line_rgb[100], 24'hFFFFFF);
    check("l50_h101", line_rgb[101], 24'hFFFFFF);
    check("l50_h102", line_rgb[102], 24'h000000);
    check("l50_h129", line_rgb[129], 24'h000000);
    check("l50_h130", line_rgb[130], 24'hFFFFFF);
    check("l50_h131", line_rgb[131], 24'hFFFFFF);
    check("l50_h132", line_rgb[132], 24'h000000);
    run_line(52);
    check("l52_h101", line_rgb[101], 24'h000000);
    check("l52_h102", line_rgb[102], 24'hFFFFFF);
    check("l52_h103", line_rgb[103], 24'hFFFFFF);
    check("l52_h104", line_rgb[104], 24'h000000);

    // Right-edge clip at (630,0) with a solid row
    write_row(0, 16'hFFFF);
    set_pos(630, 0, 1'b0, 700, 500);
    cycle(0, 480);
    run_line(0);
    check("clip_h629", line_rgb[629], 24'h000000);
    check("clip_h630", line_rgb[630], 24'hFFFFFF);
    check("clip_h639", line_rgb[639], 24'hFFFFFF);
    check("clip_h640", line_rgb[640], 24'h000000);
    check("clip_h645", line_rgb[645], 24'h000000);

    // Mid-frame update waits for the boundary
    set_pos(200, 200, 1'b0, 300, 100);
    check("mid_ready_low", pos_ready, 0);
    run_line(1);
    check("mid_old_pos_h630", line_rgb[630], 24'hFFFFFF);
    check("mid_old_pos_h200", line_rgb[200], 24'h000000);
    cycle(0, 479);
    check("mid_ready_before_boundary", pos_ready, 0);
    cycle(0, 480);
    check("mid_ready_after_boundary", pos_ready, 1);
    run_line(200);
    check("new_h199", line_rgb[199], 24'h000000);
    check("new_h200", line_rgb[200], 24'hFFFFFF);
    check("new_h231", line_rgb[231], 24'hFFFFFF);
    check("new_h232", line_rgb[232], 24'h000000);
    run_line(1);
    check("new_old_gone_h630", line_rgb[630], 24'h000000);

    // Handshake on the boundary cycle is deferred one frame
    set_pos(300, 300, 1'b0, 0, 480);
    check("bnd_ready_low", pos_ready, 0);
    run_line(200);
    check("bnd_still_old_h200", line_rgb[200], 24'hFFFFFF);
    cycle(0, 480);
    check("bnd_ready_high", pos_ready, 1);
    run_line(300);
    check("bnd_new_h299", line_rgb[299], 24'h000000);
    check("bnd_new_h300", line_rgb[300], 24'hFFFFFF);

    // Reset during DRAW drops the pending position and returns to (0,0)
    for (int h = 640; h < 644; h++) cycle(h, 299);
    for (int h = 0; h < 306; h++) begin
      if (h == 302) begin
        pos_valid = 1'b1; pos_x = 10'd500; pos_y = 10'd5;
      end
      cycle(h, 300);
      pos_valid = 1'b0;
    end
    check("pre_rst_draw", {o_r, o_g, o_b}, 24'hFFFFFF);
    check("pre_rst_ready", pos_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", {o_r, o_g, o_b}, 24'h000000);
    check("mid_rst_ready", pos_ready, 1);
    check("mid_rst_hpos", o_hpos, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int h = 306; h < 316; h++) cycle(h, 300);
    check("post_rst_idle", {o_r, o_g, o_b}, 24'h000000);
    cycle(0, 480);
    run_line(0);
    check("post_rst_h0", line_rgb[0], 24'hFFFFFF);
    check("post_rst_h31", line_rgb[31], 24'hFFFFFF);
    check("post_rst_h32", line_rgb[32], 24'h000000);
    check("post_rst_h500", line_rgb[500], 24'h000000);

`ifdef BITMAP_SPRITE_MIRROR_EN
    // Mirrored single-bit row lands on the rightmost bitmap column
    write_row(0, 16'h8000);
    set_pos(100, 50, 1'b1, 700, 500);
    cycle(0, 480);
    run_line(50);
    check("mir_h100", line_rgb[100], 24'h000000);
    check("mir_h101", line_rgb[101], 24'h000000);
    check("mir_h130", line_rgb[130], 24'hFFFFFF);
    check("mir_h131", line_rgb[131], 24'hFFFFFF);
    check("mir_h132", line_rgb[132], 24'h000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
